// File: rtl/sd_register_bank.sv
// rtl/sd_register_bank.sv - SD host register bank with RW/RO/W1C registers and a req/ack host bus
// Holds a bank of NUM_REGS registers and raises irq while any sticky event bit is set.
module sd_register_bank #(
  parameter int                          DATA_W    = 8,
  parameter int                          ADDR_W    = 8,
  parameter int                          NUM_REGS  = 16,
  parameter logic [NUM_REGS-1:0]         RO_MASK   = '0,
  parameter logic [NUM_REGS-1:0]         W1C_MASK  = '0,
  parameter logic [NUM_REGS*DATA_W-1:0]  RESET_VAL = '0
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          req_i,
  input  logic                          wnr_i,
  input  logic [ADDR_W-1:0]             address_i,
  input  logic [DATA_W-1:0]             data_in_i,
  output logic [DATA_W-1:0]             data_out_o,
  output logic                          ack_o,
  output logic                          err_o,
  input  logic [NUM_REGS*DATA_W-1:0]    hw_val_i,
  input  logic [NUM_REGS*DATA_W-1:0]    hw_set_i,
  output logic [NUM_REGS*DATA_W-1:0]    regs_out_o,
  output logic                          irq_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              wnr_q, wnr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  logic [NUM_REGS-1:0] hit;
  logic                in_range;
  logic                ro_hit;
  logic                wr_en;
  logic [DATA_W-1:0]   rd_val;

  // One-hot decode of the latched address; no hit bit means out of range.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      hit[i] = (addr_q == ADDR_W'(i));
    end
  end

  assign in_range = |hit;
  assign ro_hit   = |(hit & RO_MASK);
  assign wr_en    = (state_q == ST_EXEC) && wnr_q;

  // Hardware updates run every cycle; a bus write only lands during EXEC.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (RO_MASK[i]) begin
        regs_d[i] = hw_val_i[i*DATA_W +: DATA_W];
      end else if (W1C_MASK[i]) begin
        if (wr_en && hit[i]) begin
          regs_d[i] = (regs_q[i] & ~wdata_q) | hw_set_i[i*DATA_W +: DATA_W];
        end else begin
          regs_d[i] = regs_q[i] | hw_set_i[i*DATA_W +: DATA_W];
        end
      end else if (wr_en && hit[i]) begin
        regs_d[i] = wdata_q;
      end
    end
  end

  // Reads return the value the register takes at the EXEC edge.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (hit[i]) begin
        rd_val = regs_d[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    wnr_d   = wnr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ack_d   = ack_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          wnr_d   = wnr_i;
          addr_d  = address_i;
          wdata_d = data_in_i;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        ack_d   = 1'b1;
        state_d = ST_DONE;
        if (!in_range) begin
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (wnr_q) begin
          err_d   = ro_hit;
          rdata_d = '0;
        end else begin
          err_d   = 1'b0;
          rdata_d = rd_val;
        end
      end
      ST_DONE: begin
        if (!req_i) begin
          ack_d   = 1'b0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        ack_d   = 1'b0;
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      wnr_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VAL[i*DATA_W +: DATA_W];
      end
    end else begin
      state_q <= state_d;
      wnr_q   <= wnr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    irq_o = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (W1C_MASK[i]) begin
        irq_o = irq_o | (|regs_q[i]);
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_out
      assign regs_out_o[g*DATA_W +: DATA_W] = regs_q[g];
    end
  endgenerate

  assign data_out_o = rdata_q;
  assign ack_o      = ack_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_sd_register_bank.sv
// tb/tb_sd_register_bank.sv - scoreboard bench for sd_register_bank
// Reg 3 resets to A5, reg 1 to 11; reg 5 is RO, reg 7 is W1C.
module tb_sd_register_bank;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int NR = 16;
  localparam logic [NR-1:0]    RO  = 16'h0020;
  localparam logic [NR-1:0]    W1C = 16'h0080;
  localparam logic [NR*DW-1:0] RV  = (128'hA5 << 24) | (128'h11 << 8);

  logic           clk, reset, req, wnr;
  logic [AW-1:0]  address;
  logic [DW-1:0]  data_in, data_out;
  logic           ack, err, irq;
  logic [NR*DW-1:0] hw_val, hw_set, regs_out;
  logic [NR*DW-1:0] model;

  typedef struct {
    logic       chk_data;
    logic [7:0] data;
    logic       err;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic ack_prev = 1'b0;
  exp_t e;

  sd_register_bank #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR),
    .RO_MASK(RO), .W1C_MASK(W1C), .RESET_VAL(RV)
  ) dut (
    .clk_i(clk), .reset_i(reset), .req_i(req), .wnr_i(wnr),
    .address_i(address), .data_in_i(data_in), .data_out_o(data_out),
    .ack_o(ack), .err_o(err), .hw_val_i(hw_val), .hw_set_i(hw_set),
    .regs_out_o(regs_out), .irq_o(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Completed accesses are matched against the scoreboard on each rising ack.
  always @(negedge clk) begin
    if (ack && !ack_prev) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack actual=1 required=0");
      end else begin
        e = sb.pop_front();
        check({e.name, "_err"}, err, e.err);
        if (e.chk_data) check({e.name, "_data"}, data_out, e.data);
      end
    end
    ack_prev = ack;
  end

  task automatic access(input logic w, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] hs, input logic [7:0] xd, input logic xe,
                        input string nm);
    exp_t x;
    @(posedge clk); #1;
    req = 1'b1; wnr = w; address = a; data_in = d;
    x.chk_data = !w; x.data = xd; x.err = xe; x.name = nm;
    sb.push_back(x);
    @(posedge clk); #1;
    check({nm, "_lat1"}, ack, 1'b0);
    address = 8'hFF; data_in = ~d; wnr = ~w;
    hw_set[7*8 +: 8] = hs;
    @(posedge clk); #1;
    hw_set = '0;
    check({nm, "_lat2"}, ack, 1'b1);
    req = 1'b0; wnr = 1'b0;
    @(posedge clk); #1;
    check({nm, "_ackdrop"}, ack, 1'b0);
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; wnr = 1'b0; address = '0; data_in = '0;
    hw_val = '0; hw_val[5*8 +: 8] = 8'h81;
    hw_set = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", ack, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_data", data_out, 8'h00);
    check("rst_regs", regs_out, RV);
    check("rst_irq", irq, 1'b0);
    @(negedge clk); reset = 1'b0;
    model = RV;
    @(posedge clk); #1;
    model[5*8 +: 8] = 8'h81;
    check("ro_track", regs_out, model);

    access(1'b0, 8'd3, 8'h00, 8'h00, 8'hA5, 1'b0, "rd3");

    access(1'b1, 8'd2, 8'h3C, 8'h00, 8'h00, 1'b0, "wr2");
    model[2*8 +: 8] = 8'h3C;
    access(1'b0, 8'd2, 8'h00, 8'h00, 8'h3C, 1'b0, "rd2");
    check("regs_out_r2", regs_out[23:16], 8'h3C);

    access(1'b1, 8'd5, 8'hFF, 8'h00, 8'h00, 1'b1, "wr_ro");
    access(1'b0, 8'd5, 8'h00, 8'h00, 8'h81, 1'b0, "rd_ro");

    @(posedge clk); #1; hw_set[7*8 +: 8] = 8'h06;
    @(posedge clk); #1; hw_set = '0;
    check("w1c_set", regs_out[7*8 +: 8], 8'h06);
    check("w1c_set_irq", irq, 1'b1);
    access(1'b1, 8'd7, 8'h02, 8'h00, 8'h00, 1'b0, "w1c_clr2");
    check("w1c_clr2_reg", regs_out[7*8 +: 8], 8'h04);
    check("w1c_clr2_irq", irq, 1'b1);
    access(1'b1, 8'd7, 8'h04, 8'h00, 8'h00, 1'b0, "w1c_clr4");
    check("w1c_clr4_reg", regs_out[7*8 +: 8], 8'h00);
    check("w1c_clr4_irq", irq, 1'b0);
    access(1'b1, 8'd7, 8'h01, 8'h01, 8'h00, 1'b0, "w1c_coll");
    check("w1c_coll_reg", regs_out[7*8 +: 8], 8'h01);
    check("w1c_coll_irq", irq, 1'b1);
    model[7*8 +: 8] = 8'h01;
    access(1'b0, 8'd7, 8'h00, 8'h00, 8'h01, 1'b0, "rd7");

    access(1'b0, 8'h20, 8'h00, 8'h00, 8'h00, 1'b1, "rd_oob");
    access(1'b1, 8'h20, 8'hEE, 8'h00, 8'h00, 1'b1, "wr_oob");
    check("oob_regs", regs_out, model);

    @(posedge clk); #1;
    req = 1'b1; wnr = 1'b1; address = 8'd1; data_in = 8'h55;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("rst_exec_ack", ack, 1'b0);
    check("rst_exec_r1", regs_out[1*8 +: 8], 8'h11);
    req = 1'b0; wnr = 1'b0;
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1;
    model = RV;
    model[5*8 +: 8] = 8'h81;
    check("rst_exec_regs", regs_out, model);
    access(1'b0, 8'd1, 8'h00, 8'h00, 8'h11, 1'b0, "rd1_post_rst");

    repeat (2) @(posedge clk);
    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
